alu512_sequencer: RTL

//  Multi-cycle controller that accepts one ALU512 instruction at a time, reads both source

---
 rtl/alu512_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/alu512_sequencer.sv
// Multi-cycle ALU512 instruction sequencer. It reads two registers, drives the ALU, writes the result back
// and keeps the carry/zero flags. One instruction is in flight at a time, with a 5-cycle round trip.
module alu512_sequencer #(
  parameter int NREGS  = 8,
  parameter int REG_AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [REG_AW-1:0] instr_dst,
  input  logic [REG_AW-1:0] instr_src1,
  input  logic [REG_AW-1:0] instr_src2,
  input  logic [4:0]        instr_size,
  input  logic [4:0]        instr_off1,
  input  logic [4:0]        instr_off2,
  input  logic              instr_setflags,
  output logic              rf_rd_en,
  output logic [REG_AW-1:0] rf_rd_addr1,
  output logic [REG_AW-1:0] rf_rd_addr2,
  input  logic [511:0]      rf_rd_data1,
  input  logic [511:0]      rf_rd_data2,
  output logic [511:0]      alu_in1,
  output logic [511:0]      alu_in2,
  output logic              alu_carry_in,
  output logic [2:0]        alu_op,
  output logic [4:0]        alu_size,
  output logic [4:0]        alu_off1,
  output logic [4:0]        alu_off2,
  input  logic [511:0]      alu_res,
  input  logic              alu_carry,
  input  logic              alu_zero,
  output logic              rf_wr_en,
  output logic [REG_AW-1:0] rf_wr_addr,
  output logic [511:0]      rf_wr_data,
  output logic              flag_carry,
  output logic              flag_zero,
  output logic              busy,
  output logic              illegal
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_OPND = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4,
    ST_ILL  = 3'd5
  } state_t;

  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  state_t              state_r, state_s;
  logic                ready_r, busy_r, rd_en_r, wr_en_r, illegal_r;
  logic [2:0]          op_r;
  logic [REG_AW-1:0]   dst_r, src1_r, src2_r;
  logic [4:0]          size_r, off1_r, off2_r;
  logic                setflags_r;
  logic [511:0]        in1_r, in2_r, res_r;
  logic                res_carry_r, res_zero_r;
  logic                carry_r, zero_r;
  logic                accept_s;
  logic                arith_s;

  assign accept_s = instr_valid & ready_r;
  // ADD/SUB/ADC/SBC all have op[2] clear; only these may touch the carry flag
  assign arith_s  = ~op_r[2];

  // Next-state sequencing
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (instr_op == OP_ILLEGAL) begin
            state_s = ST_ILL;
          end else begin
            state_s = ST_READ;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: state_s = ST_OPND;
      ST_OPND: state_s = ST_EXEC;
      ST_EXEC: state_s = ST_WB;
      ST_WB:   state_s = ST_IDLE;
      ST_ILL:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register and status outputs, which are registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      ready_r   <= 1'b1;
      busy_r    <= 1'b0;
      rd_en_r   <= 1'b0;
      wr_en_r   <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      ready_r   <= (state_s == ST_IDLE);
      busy_r    <= (state_s != ST_IDLE);
      rd_en_r   <= (state_s == ST_READ);
      wr_en_r   <= (state_s == ST_WB);
      illegal_r <= (state_s == ST_ILL);
    end
  end

  // Instruction latch, loaded only on an accepted handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r       <= 3'd0;
      dst_r      <= {REG_AW{1'b0}};
      src1_r     <= {REG_AW{1'b0}};
      src2_r     <= {REG_AW{1'b0}};
      size_r     <= 5'd0;
      off1_r     <= 5'd0;
      off2_r     <= 5'd0;
      setflags_r <= 1'b0;
    end else if (accept_s) begin
      op_r       <= instr_op;
      dst_r      <= instr_dst;
      src1_r     <= instr_src1;
      src2_r     <= instr_src2;
      size_r     <= instr_size;
      off1_r     <= instr_off1;
      off2_r     <= instr_off2;
      setflags_r <= instr_setflags;
    end
  end

  // Operand capture, one cycle after the read strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in1_r <= 512'd0;
      in2_r <= 512'd0;
    end else if (state_r == ST_OPND) begin
      in1_r <= rf_rd_data1;
      in2_r <= rf_rd_data2;
    end
  end

  // Result capture once the ALU inputs have been stable for a full cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_r       <= 512'd0;
      res_carry_r <= 1'b0;
      res_zero_r  <= 1'b0;
    end else if (state_r == ST_EXEC) begin
      res_r       <= alu_res;
      res_carry_r <= alu_carry;
      res_zero_r  <= alu_zero;
    end
  end

  // Architectural flags change only at the end of write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_r <= 1'b0;
      zero_r  <= 1'b0;
    end else if ((state_r == ST_WB) && setflags_r) begin
      zero_r <= res_zero_r;
      if (arith_s) begin
        carry_r <= res_carry_r;
      end
    end
  end

  assign instr_ready  = ready_r;
  assign busy         = busy_r;
  assign illegal      = illegal_r;
  assign rf_rd_en     = rd_en_r;
  assign rf_rd_addr1  = src1_r;
  assign rf_rd_addr2  = src2_r;
  assign alu_in1      = in1_r;
  assign alu_in2      = in2_r;
  assign alu_carry_in = carry_r;
  assign alu_op       = op_r;
  assign alu_size     = size_r;
  assign alu_off1     = off1_r;
  assign alu_off2     = off2_r;
  assign rf_wr_en     = wr_en_r;
  assign rf_wr_addr   = dst_r;
  assign rf_wr_data   = res_r;
  assign flag_carry   = carry_r;
  assign flag_zero    = zero_r;

endmodule
